// File: rtl/dense_pkg.sv
// ---------------------------------------------------------------------------
// dense_pkg
// Shared definitions for the dense-layer input packer and its line store.
//   DATA_WIDTH   : default activation word width
//   LANE_WIDTH   : words consumed per inner-product kernel (one kernel = 25 lanes)
//   bank_state_t : lifecycle of one ping-pong bank
//   lines_for()  : number of wide lines needed to hold one vector
//   idx_width()  : index width for a table of n entries (never zero)
// ---------------------------------------------------------------------------
package dense_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int LANE_WIDTH = 25;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  // ceil(vec_len / (kernels * LANE_WIDTH))
  function automatic int lines_for(input int vec_len, input int kernels);
    return (vec_len + kernels * LANE_WIDTH - 1) / (kernels * LANE_WIDTH);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_line_bank.sv
// ---------------------------------------------------------------------------
// dense_line_bank
// Ping-pong line store: two banks of LINES wide lines each. The bank select
// is the outermost (most significant) index of the array.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (output reg only)
//   wr_en              : write one line
//   wr_bank, wr_line   : write location
//   wr_data            : full line to store
//   rd_en              : read strobe, data appears one cycle later
//   rd_bank, rd_line   : read location
//   rd_zero            : force the read result to zero (out-of-range line)
//   rd_data            : registered read data, held between reads
// ---------------------------------------------------------------------------
module dense_line_bank #(
  parameter int LINE_BITS = 800,
  parameter int LINES     = 3,
  parameter int LINE_AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [LINE_AW-1:0]   wr_line,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_bank,
  input  logic [LINE_AW-1:0]   rd_line,
  input  logic                 rd_zero,
  output logic [LINE_BITS-1:0] rd_data
);

  // Storage has no reset so it maps onto block RAM; only the output
  // register is cleared.
  logic [LINE_BITS-1:0] mem [2][LINES];
  logic [LINE_BITS-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_line] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= rd_zero ? '0 : mem[rd_bank][rd_line];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/dense_vec_packer.sv
// ---------------------------------------------------------------------------
// dense_vec_packer
// Receives a vector as a stream of IN_WORDS-wide writes, repacks it into
// lines of KERNEL_NUM*25 words (last line zero-padded) and stores whole
// vectors in a ping-pong pair of banks. layer_enable pulses once per vector
// when the bank at the read pointer becomes available to the consumer.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_wr_en      : incoming group valid
//   in_addr       : group index within the vector
//   in_data       : IN_WORDS words, word k at bits [(k+1)*DW-1 : k*DW]
//   out_rd_en     : consumer read strobe
//   out_rd_addr   : line index to read (>= LINES reads zero)
//   out_rd_data   : registered line, lane j at bits [(j+1)*DW-1 : j*DW]
//   out_done      : consumer is finished with the current read bank
//   layer_enable  : one-cycle pulse, read bank holds a full vector
//   overflow      : sticky, a write was dropped (no free bank)
//   seq_err       : sticky, in_addr differed from the expected index
// ---------------------------------------------------------------------------
module dense_vec_packer #(
  parameter int DATA_WIDTH = dense_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 16,
  parameter int IN_WORDS   = 2,
  parameter int VEC_LEN    = 120,
  parameter int KERNEL_NUM = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 in_wr_en,
  input  logic [ADDR_WIDTH-1:0]                                in_addr,
  input  logic [IN_WORDS*DATA_WIDTH-1:0]                       in_data,
  input  logic                                                 out_rd_en,
  input  logic [ADDR_WIDTH-1:0]                                out_rd_addr,
  output logic [KERNEL_NUM*dense_pkg::LANE_WIDTH*DATA_WIDTH-1:0] out_rd_data,
  input  logic                                                 out_done,
  output logic                                                 layer_enable,
  output logic                                                 overflow,
  output logic                                                 seq_err
);

  import dense_pkg::*;

  localparam int LINE_WORDS = KERNEL_NUM * LANE_WIDTH;
  localparam int LINE_BITS  = LINE_WORDS * DATA_WIDTH;
  localparam int LINES      = lines_for(VEC_LEN, KERNEL_NUM);
  localparam int PAIRS      = VEC_LEN / IN_WORDS;
  localparam int LINE_AW    = idx_width(LINES);
  localparam int LANE_AW    = $clog2(LINE_WORDS + 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  bank_state_t           bank_state_reg [2];
  logic                  wr_bank_reg;
  logic                  rd_bank_reg;
  logic [LINE_AW-1:0]    line_ptr_reg;
  logic [LANE_AW-1:0]    lane_ptr_reg;
  logic [ADDR_WIDTH-1:0] exp_addr_reg;
  logic                  layer_enable_reg;
  logic                  overflow_reg;
  logic                  seq_err_reg;

  // ---------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------
  logic                  wr_open;
  logic                  wr_accept;
  logic                  wr_drop;
  logic                  addr_mismatch;
  logic                  resync;
  logic                  last_pair;
  logic                  commit;
  logic [LANE_AW-1:0]    eff_lane;
  logic [LANE_AW-1:0]    lane_after;
  logic [LINE_AW-1:0]    eff_line;
  logic [ADDR_WIDTH-1:0] eff_exp;
  logic [LINE_BITS-1:0]  merged_line;
  logic                  rd_oob;

  always_comb begin
    wr_open       = (bank_state_reg[wr_bank_reg] == BANK_EMPTY) ||
                    (bank_state_reg[wr_bank_reg] == BANK_FILLING);
    wr_accept     = in_wr_en && wr_open;
    wr_drop       = in_wr_en && !wr_open;
    addr_mismatch = (in_addr != exp_addr_reg);
    // An out-of-order index 0 restarts the current bank from scratch; any
    // other wrong index is simply placed where the next group was expected.
    resync        = wr_accept && addr_mismatch && (in_addr == '0);
    eff_lane      = resync ? '0 : lane_ptr_reg;
    eff_line      = resync ? '0 : line_ptr_reg;
    eff_exp       = resync ? '0 : exp_addr_reg;
    lane_after    = eff_lane + LANE_AW'(IN_WORDS);
    last_pair     = (eff_exp == ADDR_WIDTH'(PAIRS - 1));
    commit        = wr_accept && ((lane_after == LANE_AW'(LINE_WORDS)) || last_pair);
    rd_oob        = (out_rd_addr >= ADDR_WIDTH'(LINES));
  end

  // ---------------------------------------------------------------------
  // Staging line: one register per lane. The incoming group lands on the
  // lanes of its slot; the merged line (not the stale staging contents) is
  // what gets committed, so a commit and the final write happen together.
  // Clearing after each commit is what zero-pads the last line.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_lane
    localparam int SLOT = (gi / IN_WORDS) * IN_WORDS;
    localparam int WORD = gi % IN_WORDS;

    logic [DATA_WIDTH-1:0] stage_reg;
    logic [DATA_WIDTH-1:0] base_word;
    logic                  hit;

    assign base_word = resync ? '0 : stage_reg;
    assign hit       = wr_accept && (eff_lane == LANE_AW'(SLOT));
    assign merged_line[gi*DATA_WIDTH +: DATA_WIDTH] =
      hit ? in_data[WORD*DATA_WIDTH +: DATA_WIDTH] : base_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_reg <= '0;
      end else if (commit) begin
        stage_reg <= '0;
      end else if (wr_accept) begin
        stage_reg <= merged_line[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bank FSMs and pointers. Write side only ever touches a bank that is
  // EMPTY/FILLING and read side only one that is FULL/READING, so both may
  // act in the same cycle without conflict.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state_reg[0] <= BANK_EMPTY;
      bank_state_reg[1] <= BANK_EMPTY;
      wr_bank_reg       <= 1'b0;
      rd_bank_reg       <= 1'b0;
      line_ptr_reg      <= '0;
      lane_ptr_reg      <= '0;
      exp_addr_reg      <= '0;
      layer_enable_reg  <= 1'b0;
      overflow_reg      <= 1'b0;
      seq_err_reg       <= 1'b0;
    end else begin
      layer_enable_reg <= 1'b0;

      if (wr_drop) begin
        overflow_reg <= 1'b1;
      end

      if (wr_accept) begin
        if (addr_mismatch) begin
          seq_err_reg <= 1'b1;
        end
        if (commit && last_pair) begin
          bank_state_reg[wr_bank_reg] <= BANK_FULL;
          wr_bank_reg                 <= ~wr_bank_reg;
          line_ptr_reg                <= '0;
          lane_ptr_reg                <= '0;
          exp_addr_reg                <= '0;
        end else begin
          bank_state_reg[wr_bank_reg] <= BANK_FILLING;
          exp_addr_reg                <= eff_exp + ADDR_WIDTH'(1);
          if (commit) begin
            lane_ptr_reg <= '0;
            line_ptr_reg <= eff_line + LINE_AW'(1);
          end else begin
            lane_ptr_reg <= lane_after;
            line_ptr_reg <= eff_line;
          end
        end
      end

      // A freshly toggled read pointer is examined on the following cycle,
      // which gives the two-cycle announce latency after out_done.
      if (out_done && (bank_state_reg[rd_bank_reg] == BANK_READING)) begin
        bank_state_reg[rd_bank_reg] <= BANK_EMPTY;
        rd_bank_reg                 <= ~rd_bank_reg;
      end else if (bank_state_reg[rd_bank_reg] == BANK_FULL) begin
        bank_state_reg[rd_bank_reg] <= BANK_READING;
        layer_enable_reg            <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Line store
  // ---------------------------------------------------------------------
  dense_line_bank #(
    .LINE_BITS (LINE_BITS),
    .LINES     (LINES),
    .LINE_AW   (LINE_AW)
  ) u_line_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (commit),
    .wr_bank (wr_bank_reg),
    .wr_line (eff_line),
    .wr_data (merged_line),
    .rd_en   (out_rd_en),
    .rd_bank (rd_bank_reg),
    .rd_line (out_rd_addr[LINE_AW-1:0]),
    .rd_zero (rd_oob),
    .rd_data (out_rd_data)
  );

  assign layer_enable = layer_enable_reg;
  assign overflow     = overflow_reg;
  assign seq_err      = seq_err_reg;

endmodule

// File: doc/dense_vec_packer.md
# dense_vec_packer

Input-side receiver for a dense layer fed by the previous dense layer's narrow write port (`wr_en`/`addr`/`data`, IN_WORDS activations per write). It repacks the stream into wide lines of KERNEL_NUM×25 words, zero-pads the last line, and stores whole vectors in a ping-pong pair of banks. It pulses `layer_enable` when a complete vector is ready for the consuming layer's line-wide inner-product engine.

## Interface
- DATA_WIDTH, 16, activation word width
- ADDR_WIDTH, 16, address width of both ports
- IN_WORDS, 2, words per incoming write
- VEC_LEN, 120, vector length in words; multiple of IN_WORDS
- KERNEL_NUM, 2, consumer inner-product kernels; LINE_WORDS = KERNEL_NUM*25
- LINES, derived ceil(VEC_LEN/LINE_WORDS) = 3, lines per bank

Ports:
- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low
- in_wr_en  in  1  incoming pair valid
- in_addr  in  ADDR_WIDTH  pair index, 0..VEC_LEN/IN_WORDS-1
- in_data  in  IN_WORDS*DATA_WIDTH  word k at bits [(k+1)*DW-1 : k*DW]; lower word = lower index
- out_rd_en  in  1  consumer read strobe
- out_rd_addr  in  ADDR_WIDTH  line index 0..LINES-1
- out_rd_data  out  LINE_WORDS*DATA_WIDTH  registered line; lane j at bits [(j+1)*DW-1 : j*DW]
- out_done  in  1  one-cycle pulse: consumer finished with current read bank
- layer_enable  out  1  one-cycle pulse: read bank holds a full vector
- overflow  out  1  sticky: write dropped because no empty bank
- seq_err  out  1  sticky: in_addr not equal to expected pair index

## Operation
- Bank state, each of 2 banks: EMPTY → FILLING → FULL → READING → EMPTY.
- Write side: pointers wr_bank, line_ptr, lane_ptr, exp_addr. 50-lane staging register, cleared to zero at reset and after every line commit, so the last line pads with zeros.
- Accepted write: in_data merges into staging at lane_ptr. lane_ptr advances by IN_WORDS. LINE_WORDS is a multiple of IN_WORDS, so a pair never straddles lines.
- Commit: when lane_ptr reaches LINE_WORDS, or the pair is the final pair (exp_addr = VEC_LEN/IN_WORDS-1), the merged staging line is written to bank[wr_bank][line_ptr]. line_ptr then increments; at frame end it resets to 0.
- Frame end: bank → FULL, wr_bank toggles, exp_addr → 0.
- Sequence check, in_addr ≠ exp_addr:
  - seq_err set.
  - If in_addr = 0: resync. Staging and pointers clear, the pair is taken as pair 0 of the same bank, and the partially written lines are overwritten.
  - Otherwise: pair written at the expected position.
- Overflow: write while bank[wr_bank] ≠ EMPTY/FILLING → dropped, overflow set, no state change.
- Read side: rd_bank pointer.
  - FULL bank at rd_bank with consumer idle → layer_enable pulse, bank → READING.
  - out_rd_en reads bank[rd_bank][out_rd_addr]. out_rd_addr ≥ LINES returns zero.
  - out_done while READING → bank EMPTY, rd_bank toggles. The other bank, if FULL, is announced per the timing below.
  - out_done while not READING: ignored.
- Arithmetic: no arithmetic on data; pure placement. Pointers wrap modulo their limits.

## Timing
- Reset values: out_rd_data 0, layer_enable 0, overflow 0, seq_err 0, both banks EMPTY, wr_bank = rd_bank = 0, all pointers 0, staging 0.
- in_wr_en at edge t: staging/commit at t+1. Final pair at t: bank FULL at t+1, layer_enable high during cycle t+2 if rd side is idle.
- Read latency 1: out_rd_en at edge t, out_rd_data valid after t+1, held until the next read.
- out_done at t with other bank FULL: layer_enable during t+2.
- Simultaneous final write and out_done for the other bank: both take effect. The new bank's layer_enable follows at t+2.
- Writes may be back-to-back every cycle; no backpressure.
- Reset mid-frame: partial frame discarded, all banks EMPTY.

## Structure
- Shared package `dense_pkg`:
  - DATA_WIDTH, LANE_WIDTH = 25
  - bank-state enum (EMPTY, FILLING, FULL, READING)
  - lines_for(vec_len, kernels) ceil function
- Sub-module `dense_line_bank`: 2×LINES deep, LINE_WORDS*DATA_WIDTH wide; one write port, one registered read port; bank select as the address MSB.

## Test plan
- Full frame: 60 pairs, word i = i+1, pairs back-to-back.
  - layer_enable single pulse 2 cycles after the last write.
  - Line 0 lane 0 = 1; line 1 lane 0 = 51; line 2 lane 19 = 120; line 2 lanes 20..49 = 0.
- Ping-pong: second frame (word = 1000+i) written while bank 0 is READING.
  - No layer_enable until out_done.
  - Pulse 2 cycles after out_done; line 0 lane 0 = 1000.
- Overflow: third frame while both banks are occupied → overflow = 1; bank contents unchanged; later frames accepted after out_done.
- Sequence: pairs 0..9 then in_addr = 12 → seq_err = 1, data at pair 10 slot. Then in_addr = 0 → refill from pair 0; frame completes with correct contents.
- Padding after reuse: frame of all 0xFFFF, then frame of all 0x0001 → line 2 lanes 20..49 still 0.
- Reset after 30 pairs: outputs zero, no layer_enable; a fresh full frame then behaves as in scenario 1.
